// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave register-bank controller:
// phase encoding, register indices, default slave address and the
// STATUS register layout.
package i2c_slave_pkg;

  // Transaction phase seen by the register controller
  localparam logic [1:0] PH_IDLE = 2'd0;  // no transaction in progress
  localparam logic [1:0] PH_PTR  = 2'd1;  // next received byte is the register pointer
  localparam logic [1:0] PH_DATA = 2'd2;  // received bytes are register data

  // Register map
  localparam int REG_SLAVE_ADDR = 0;
  localparam int REG_STATUS     = 1;

  // Slave address used after reset
  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h42;

  // STATUS byte: bits [7:4] read as zero, bits [3:0] hold the I2C write count
  function automatic logic [7:0] status_byte(input logic [3:0] wr_cnt);
    return {4'h0, wr_cnt};
  endfunction

endpackage

// File: rtl/i2c_reg_bank.sv
// NREGS x 8-bit register file: one write port, two asynchronous read
// ports (I2C side and host side) and a per-register write-protect mask.
// Register 0 resets to REG0_RST, all others to zero. The low 7 bits of
// register 0 are also tapped out for the slave-address shadow.
module i2c_reg_bank
  import i2c_slave_pkg::*;
#(
  parameter int               NREGS    = 16,
  parameter int               AW       = 4,
  parameter logic [7:0]       REG0_RST = 8'h00,
  parameter logic [NREGS-1:0] WP_MASK  = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [7:0]    o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [7:0]    o_rdata_b,
  output logic [6:0]    o_reg0_addr
);

  logic [7:0] r_regs [NREGS];

  // Register storage; writes to protected registers are silently dropped
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= (i == REG_SLAVE_ADDR) ? REG0_RST : 8'h00;
      end
    end else if (i_we && !WP_MASK[i_waddr]) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a   = r_regs[i_raddr_a];
  assign o_rdata_b   = r_regs[i_raddr_b];
  assign o_reg0_addr = r_regs[REG_SLAVE_ADDR][6:0];

endmodule

// File: rtl/i2c_slave_reg_ctrl.sv
// Register-bank controller behind the I2C slave FSM. Converts the FSM's
// byte-received / byte-request levels into pointer-addressed register
// accesses with auto-increment, arbitrates the bank against a local host
// port, and drives the FSM's slave address from register 0 through a
// shadow that only updates between transactions.
//
// Host handshake: the host raises i_host_req with i_host_we/i_host_addr/
// i_host_wdata stable and holds them until o_host_ack. o_host_ack is a
// single-cycle pulse; o_host_rdata is valid only while o_host_ack=1. A
// request is accepted in any cycle without an I2C rd/wr pulse and is
// acknowledged on the following cycle. The host must drop or change the
// request in the cycle after the ack; the ack cycle never re-accepts.
module i2c_slave_reg_ctrl
  import i2c_slave_pkg::*;
#(
  parameter int         NREGS        = 16,
  parameter int         AW           = 4,
  parameter logic [6:0] DEFAULT_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_start_det,
  input  logic          i_stop_det,
  input  logic          i_wr_en,
  input  logic [7:0]    i_wr_data,
  input  logic          i_rd_en,
  output logic [7:0]    o_rd_data,
  output logic [6:0]    o_slave_addr,
  input  logic          i_host_req,
  input  logic          i_host_we,
  input  logic [AW-1:0] i_host_addr,
  input  logic [7:0]    i_host_wdata,
  output logic          o_host_ack,
  output logic [7:0]    o_host_rdata,
  output logic [1:0]    o_phase,
  output logic [AW-1:0] o_ptr
);

  localparam logic [AW-1:0]    SLAVE_IDX  = AW'(REG_SLAVE_ADDR);
  localparam logic [AW-1:0]    STATUS_IDX = AW'(REG_STATUS);
  // STATUS is maintained outside the bank, so its bank slot is never written
  localparam logic [NREGS-1:0] WP_MASK    = {{(NREGS-1){1'b0}}, 1'b1} << REG_STATUS;

  logic          r_wr_en_q;
  logic          r_rd_en_q;
  logic [1:0]    r_phase;
  logic [AW-1:0] r_ptr;
  logic [3:0]    r_wr_cnt;
  logic [7:0]    r_rd_data;
  logic [6:0]    r_slave_addr;
  logic          r_host_ack;
  logic [7:0]    r_host_rdata;

  logic          w_wr_pulse;
  logic          w_rd_pulse;
  logic          w_active;
  logic          w_ptr_byte;
  logic          w_i2c_wr;
  logic          w_host_serve;
  logic          w_host_wr;
  logic          w_bank_we;
  logic [AW-1:0] w_bank_waddr;
  logic [7:0]    w_bank_wdata;
  logic [7:0]    w_rdata_i2c;
  logic [7:0]    w_rdata_host;
  logic [6:0]    w_reg0_now;
  logic [6:0]    w_reg0_next;

  // Value presented to a reader: reg 0 bit 7 reads 0, STATUS comes from the counter
  function automatic logic [7:0] reg_view(input logic [AW-1:0] idx,
                                          input logic [7:0]    raw,
                                          input logic [3:0]    cnt);
    logic [7:0] v;
    if (idx == SLAVE_IDX) begin
      v = {1'b0, raw[6:0]};
    end else if (idx == STATUS_IDX) begin
      v = status_byte(cnt);
    end else begin
      v = raw;
    end
    return v;
  endfunction

  // One action per byte: only the rising edge of each FSM level counts
  assign w_wr_pulse   = i_wr_en & ~r_wr_en_q;
  assign w_rd_pulse   = i_rd_en & ~r_rd_en_q;
  assign w_active     = (r_phase != PH_IDLE);
  assign w_ptr_byte   = w_wr_pulse && (r_phase == PH_PTR);
  assign w_i2c_wr     = w_wr_pulse && (r_phase == PH_DATA);

  // I2C pulses own the cycle; the host gets any other cycle not spent acking
  assign w_host_serve = i_host_req && !r_host_ack && !w_wr_pulse && !w_rd_pulse;
  assign w_host_wr    = w_host_serve && i_host_we;

  // Single bank write port shared between the I2C data write and a host write
  always_comb begin
    w_bank_we    = 1'b0;
    w_bank_waddr = r_ptr;
    w_bank_wdata = i_wr_data;
    if (w_i2c_wr) begin
      w_bank_we = 1'b1;
    end else if (w_host_wr) begin
      w_bank_we    = 1'b1;
      w_bank_waddr = i_host_addr;
      w_bank_wdata = i_host_wdata;
    end
  end

  // Register 0 as it will be after this cycle's write, for a same-cycle stop
  assign w_reg0_next = (w_bank_we && (w_bank_waddr == SLAVE_IDX)) ? w_bank_wdata[6:0]
                                                                  : w_reg0_now;

  i2c_reg_bank #(
    .NREGS    (NREGS),
    .AW       (AW),
    .REG0_RST ({1'b0, DEFAULT_ADDR}),
    .WP_MASK  (WP_MASK)
  ) u_bank (
    .clk         (clk),
    .rstn        (rstn),
    .i_we        (w_bank_we),
    .i_waddr     (w_bank_waddr),
    .i_wdata     (w_bank_wdata),
    .i_raddr_a   (r_ptr),
    .o_rdata_a   (w_rdata_i2c),
    .i_raddr_b   (i_host_addr),
    .o_rdata_b   (w_rdata_host),
    .o_reg0_addr (w_reg0_now)
  );

  // Previous level of the FSM strobes for edge detection
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_en_q <= 1'b0;
      r_rd_en_q <= 1'b0;
    end else begin
      r_wr_en_q <= i_wr_en;
      r_rd_en_q <= i_rd_en;
    end
  end

  // Phase FSM: stop beats start, start beats the pointer-byte transition
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= PH_IDLE;
    end else if (i_stop_det) begin
      r_phase <= PH_IDLE;
    end else if (i_start_det) begin
      r_phase <= PH_PTR;
    end else if (w_ptr_byte) begin
      r_phase <= PH_DATA;
    end
  end

  // Register pointer: loaded by the first byte, bumped by every data write or read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= '0;
    end else if (w_ptr_byte) begin
      r_ptr <= i_wr_data[AW-1:0];
    end else if (w_i2c_wr || (w_rd_pulse && w_active)) begin
      r_ptr <= r_ptr + AW'(1);
    end
  end

  // Transmit byte for the FSM; outside a transaction the bus sees 0xFF
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rd_data <= 8'h00;
    end else if (w_rd_pulse) begin
      r_rd_data <= w_active ? reg_view(r_ptr, w_rdata_i2c, r_wr_cnt) : 8'hFF;
    end
  end

  // Saturating count of I2C data bytes that actually landed in a register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_cnt <= 4'h0;
    end else if (w_i2c_wr && (r_ptr != STATUS_IDX) && (r_wr_cnt != 4'hF)) begin
      r_wr_cnt <= r_wr_cnt + 4'd1;
    end
  end

  // Host ack pulse and read data capture
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_host_ack   <= 1'b0;
      r_host_rdata <= 8'h00;
    end else begin
      r_host_ack <= w_host_serve;
      if (w_host_serve && !i_host_we) begin
        r_host_rdata <= reg_view(i_host_addr, w_rdata_host, r_wr_cnt);
      end
    end
  end

  // Slave-address shadow: reloads at stop, or at once for an idle host write
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_slave_addr <= DEFAULT_ADDR;
    end else if (i_stop_det) begin
      r_slave_addr <= w_reg0_next;
    end else if (w_host_wr && (i_host_addr == SLAVE_IDX) && !w_active) begin
      r_slave_addr <= i_host_wdata[6:0];
    end
  end

  assign o_rd_data    = r_rd_data;
  assign o_slave_addr = r_slave_addr;
  assign o_host_ack   = r_host_ack;
  assign o_host_rdata = r_host_rdata;
  assign o_phase      = r_phase;
  assign o_ptr        = r_ptr;

endmodule
